// File: rtl/sram_pkg.sv
// Shared types and helpers for sram_be_pipe (state encoding, latency bounds, byte merge).
// Parity helper is only used when SRAM_PARITY_EN is defined.
package sram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } sram_state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  // One byte lane of a byte-enable write: keep the old byte unless enabled.
  function automatic logic [7:0] merge(input logic [7:0] old_b, input logic [7:0] new_b,
                                       input logic be);
    return be ? new_b : old_b;
  endfunction

  function automatic logic parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Raw storage with byte-enable write port and a registered read of the merged word.
// With SRAM_PARITY_EN defined each byte carries an even-parity bit checked on access.
module sram_array
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                i_clk,
  input  logic                i_en,
  input  logic                i_we,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_perr
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [NB-1:0]     w_wbe;
  logic [DATA_W-1:0] w_merged;

  assign w_wbe = i_we ? i_be : '0;

  // A read is a write with no lanes enabled, so the read port always sees the merged word.
  always_comb begin
    w_merged = '0;
    for (int i = 0; i < NB; i++) begin
      w_merged[8*i +: 8] = merge(r_mem[i_addr][8*i +: 8], i_wdata[8*i +: 8], w_wbe[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int i = 0; i < NB; i++) begin
        if (w_wbe[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
      r_rdata <= w_merged;
    end
  end

  assign o_rdata = r_rdata;

`ifdef SRAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_par_bad;
  logic          r_perr;

  // Freshly written lanes cannot be in error; only retained lanes are checked.
  always_comb begin
    w_par_bad = '0;
    for (int i = 0; i < NB; i++) begin
      w_par_bad[i] = !w_wbe[i] && (parity(r_mem[i_addr][8*i +: 8]) != r_par[i_addr][i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int i = 0; i < NB; i++) begin
        if (w_wbe[i]) r_par[i_addr][i] <= parity(i_wdata[8*i +: 8]);
      end
      r_perr <= |w_par_bad;
    end
  end

  assign o_perr = r_perr;
`else
  assign o_perr = 1'b0;
`endif

endmodule

// File: rtl/sram_be_pipe.sv
// Single-port SRAM with req/ready handshake, byte enables, 1- or 2-cycle read latency and
// post-reset zero-fill. Optional per-byte parity checking via SRAM_PARITY_EN.
module sram_be_pipe
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned INIT_CLEAR = 1,
  parameter int unsigned WR_THROUGH = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req,
  output logic                o_ready,
  input  logic                i_we,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_din,
  output logic [DATA_W-1:0]   o_dout,
  output logic                o_dvalid,
  output logic                o_perr
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("sram_be_pipe: RD_LAT must be 1 or 2");
  end
  if (DATA_W == 0 || DATA_W % 8 != 0) begin : g_bad_data_w
    $error("sram_be_pipe: DATA_W must be a non-zero multiple of 8");
  end

  sram_state_e       r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (INIT_CLEAR == 0 || (&r_cnt)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
          r_cnt <= r_cnt + ADDR_W'(1);
        end
        ST_RUN: r_ready <= 1'b1;
      endcase
    end
  end

  assign o_ready = r_ready;

  logic w_clr;
  logic w_acc;
  logic w_issue;

  assign w_clr   = (r_state == ST_CLEAR) && (INIT_CLEAR != 0) && !i_rst;
  assign w_acc   = i_req && r_ready && !i_rst;
  assign w_issue = w_acc && (!i_we || (WR_THROUGH != 0));

  logic [DATA_W-1:0] w_arr_rdata;
  logic              w_arr_perr;

  sram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .i_clk  (i_clk),
    .i_en   (w_clr || w_acc),
    .i_we   (w_clr || i_we),
    .i_be   (w_clr ? '1 : i_be),
    .i_addr (w_clr ? r_cnt : i_addr),
    .i_wdata(w_clr ? '0 : i_din),
    .o_rdata(w_arr_rdata),
    .o_perr (w_arr_perr)
  );

  // Marks that the array read register holds a word destined for DOUT.
  logic r_vld0;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_vld0 <= 1'b0;
    else       r_vld0 <= w_issue;
  end

  logic [DATA_W-1:0] w_stg_data;
  logic              w_stg_perr;
  logic              w_stg_vld;

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] r_stg_data;
    logic              r_stg_perr;
    logic              r_stg_vld;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_stg_vld <= 1'b0;
      end else begin
        r_stg_vld <= r_vld0;
      end
      r_stg_data <= w_arr_rdata;
      r_stg_perr <= w_arr_perr;
    end

    assign w_stg_data = r_stg_data;
    assign w_stg_perr = r_stg_perr;
    assign w_stg_vld  = r_stg_vld;
  end else begin : g_lat1
    assign w_stg_data = w_arr_rdata;
    assign w_stg_perr = w_arr_perr;
    assign w_stg_vld  = r_vld0;
  end

  logic [DATA_W-1:0] r_dout;
  logic              r_dvalid;
  logic              r_perr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_dvalid <= w_stg_vld;
      if (w_stg_vld) begin
        r_dout <= w_stg_data;
        r_perr <= w_stg_perr;
      end
    end
  end

  assign o_dout   = r_dout;
  assign o_dvalid = r_dvalid;
  assign o_perr   = r_perr;

endmodule

// File: tb/tb_sram_be_pipe.sv
// Directed bench for sram_be_pipe: three instances (RD_LAT=1, RD_LAT=2 + write-through,
// no zero-fill) share stimulus. Parity section runs only with SRAM_PARITY_EN defined.
module tb_sram_be_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [3:0]  addr;
  logic [31:0] din;

  logic        a_ready, a_dvalid, a_perr;
  logic [31:0] a_dout;
  logic        b_ready, b_dvalid, b_perr;
  logic [31:0] b_dout;
  logic        c_ready, c_dvalid, c_perr;
  logic [31:0] c_dout;

  sram_be_pipe #(
    .DATA_W(32), .ADDR_W(4), .RD_LAT(1), .INIT_CLEAR(1), .WR_THROUGH(0)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_ready(a_ready), .i_we(we), .i_be(be),
    .i_addr(addr), .i_din(din), .o_dout(a_dout), .o_dvalid(a_dvalid), .o_perr(a_perr)
  );

  sram_be_pipe #(
    .DATA_W(32), .ADDR_W(4), .RD_LAT(2), .INIT_CLEAR(1), .WR_THROUGH(1)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_ready(b_ready), .i_we(we), .i_be(be),
    .i_addr(addr), .i_din(din), .o_dout(b_dout), .o_dvalid(b_dvalid), .o_perr(b_perr)
  );

  sram_be_pipe #(
    .DATA_W(32), .ADDR_W(4), .RD_LAT(1), .INIT_CLEAR(0), .WR_THROUGH(0)
  ) dut_c (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_ready(c_ready), .i_we(we), .i_be(be),
    .i_addr(addr), .i_din(din), .o_dout(c_dout), .o_dvalid(c_dvalid), .o_perr(c_perr)
  );

  typedef struct {
    int          edge_n;
    logic [31:0] data;
    logic        perr;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  logic  last_perr;

  always @(posedge clk) cyc++;

  // Each DVALID beat is logged with the index of the edge that produced it.
  always @(negedge clk) begin
    if (a_dvalid) qa.push_back('{cyc, a_dout, a_perr});
    if (b_dvalid) qb.push_back('{cyc, b_dout, b_perr});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic w, input logic [3:0] b, input logic [3:0] a,
                    input logic [31:0] d, output int n);
    req = 1'b1; we = w; be = b; addr = a; din = d;
    tick();
    n = cyc;
  endtask

  task automatic idle(input int k);
    req = 1'b0; we = 1'b0;
    repeat (k) tick();
  endtask

  task automatic pop(input bit sel_b, input string tag, input int exp_edge,
                     input logic [31:0] exp_data);
    beat_t bt;
    int    sz;
    sz = sel_b ? qb.size() : qa.size();
    check({tag, "_seen"}, 32'(sz != 0), 1);
    if (sz != 0) begin
      if (sel_b) bt = qb.pop_front();
      else       bt = qa.pop_front();
      last_perr = bt.perr;
      check({tag, "_edge"}, 32'(bt.edge_n), 32'(exp_edge));
      check({tag, "_data"}, bt.data, exp_data);
    end
  endtask

  task automatic no_extra(input string tag);
    check({tag, "_a_extra"}, 32'(qa.size()), 0);
    check({tag, "_b_extra"}, 32'(qb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, n2, n3, cnt;
    rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0;
    tick(); tick();
    check("rst_a_ready",  32'(a_ready),  0);
    check("rst_a_dvalid", 32'(a_dvalid), 0);
    check("rst_a_dout",   a_dout,        0);
    check("rst_a_perr",   32'(a_perr),   0);
    check("rst_b_ready",  32'(b_ready),  0);
    check("rst_c_ready",  32'(c_ready),  0);

    // Zero-fill takes DEPTH edges; the no-clear instance is ready after one.
    rst = 1'b0;
    tick(); cnt = 1;
    check("noclr_c_ready", 32'(c_ready), 1);
    while (!a_ready && cnt < 40) begin tick(); cnt++; end
    check("clr_edges", 32'(cnt), 16);
    check("clr_b_ready", 32'(b_ready), 1);
    no_extra("clr");

    n1 = 0;
    for (int i = 0; i < 16; i++) begin
      op(1'b0, 4'h0, 4'(i), 32'h0, n);
      if (i == 0) n1 = n;
    end
    idle(4);
    for (int i = 0; i < 16; i++) begin
      pop(1'b0, $sformatf("clr_a%0d", i), n1 + i + 1, 32'h0);
      pop(1'b1, $sformatf("clr_b%0d", i), n1 + i + 2, 32'h0);
    end
    no_extra("t1");

    // Byte-enable merge, including a BE=0 no-op write.
    op(1'b1, 4'hF, 4'd5, 32'hDEADBEEF, n1);
    op(1'b1, 4'h4, 4'd5, 32'h00AA0000, n2);
    op(1'b1, 4'h0, 4'd5, 32'hFFFFFFFF, n3);
    op(1'b0, 4'h0, 4'd5, 32'h0, n);
    idle(4);
    pop(1'b0, "be_a",   n + 1,  32'hDEAABEEF);
    pop(1'b1, "be_wt1", n1 + 2, 32'hDEADBEEF);
    pop(1'b1, "be_wt2", n2 + 2, 32'hDEAABEEF);
    pop(1'b1, "be_wt0", n3 + 2, 32'hDEAABEEF);
    pop(1'b1, "be_b",   n + 2,  32'hDEAABEEF);
    no_extra("t2");
    check("hold_a_dout",   a_dout,        32'hDEAABEEF);
    check("hold_a_dvalid", 32'(a_dvalid), 0);

    // Back-to-back reads keep order and one beat each.
    op(1'b1, 4'hF, 4'd1, 32'h11111111, n1);
    op(1'b1, 4'hF, 4'd2, 32'h22222222, n2);
    op(1'b1, 4'hF, 4'd3, 32'h33333333, n3);
    op(1'b0, 4'h0, 4'd1, 32'h0, n);
    op(1'b0, 4'h0, 4'd2, 32'h0, cnt);
    op(1'b0, 4'h0, 4'd3, 32'h0, cnt);
    idle(4);
    pop(1'b0, "b2b_a1", n + 1, 32'h11111111);
    pop(1'b0, "b2b_a2", n + 2, 32'h22222222);
    pop(1'b0, "b2b_a3", n + 3, 32'h33333333);
    pop(1'b1, "b2b_w1", n1 + 2, 32'h11111111);
    pop(1'b1, "b2b_w2", n2 + 2, 32'h22222222);
    pop(1'b1, "b2b_w3", n3 + 2, 32'h33333333);
    pop(1'b1, "b2b_b1", n + 2, 32'h11111111);
    pop(1'b1, "b2b_b2", n + 3, 32'h22222222);
    pop(1'b1, "b2b_b3", n + 4, 32'h33333333);
    no_extra("t3");

    // Write then read of the same address on the next edge.
    op(1'b1, 4'hF, 4'd7, 32'h000000AA, n1);
    op(1'b0, 4'h0, 4'd7, 32'h0, n);
    idle(4);
    pop(1'b0, "raw_a",  n + 1,  32'h000000AA);
    pop(1'b1, "raw_wt", n1 + 2, 32'h000000AA);
    pop(1'b1, "raw_b",  n + 2,  32'h000000AA);
    no_extra("t5");

`ifdef SRAM_PARITY_EN
    dut_a.u_array.r_mem[9] = dut_a.u_array.r_mem[9] ^ 32'h8;
    op(1'b0, 4'h0, 4'd9, 32'h0, n);
    idle(3);
    pop(1'b0, "par_bad", n + 1, 32'h00000008);
    check("par_bad_perr", 32'(last_perr), 1);
    op(1'b0, 4'h0, 4'd10, 32'h0, n);
    idle(3);
    pop(1'b0, "par_ok", n + 1, 32'h0);
    check("par_ok_perr", 32'(last_perr), 0);
    qb.delete();
`endif

    // Reset with a read in flight drops it, then reset mid-clear restarts the counter.
    op(1'b0, 4'h0, 4'd5, 32'h0, n);
    req = 1'b0; rst = 1'b1;
    tick(); tick();
    no_extra("flush");
    check("rrst_a_ready",  32'(a_ready),  0);
    check("rrst_a_dvalid", 32'(a_dvalid), 0);
    check("rrst_a_dout",   a_dout,        0);
    rst = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check("midclr_a_ready", 32'(a_ready), 0);
    rst = 1'b0;
    cnt = 0;
    while (!a_ready && cnt < 40) begin tick(); cnt++; end
    check("reclr_edges", 32'(cnt), 16);
    op(1'b0, 4'h0, 4'd5, 32'h0, n);
    op(1'b0, 4'h0, 4'd7, 32'h0, cnt);
    idle(4);
    pop(1'b0, "reclr_a5", n + 1, 32'h0);
    pop(1'b0, "reclr_a7", n + 2, 32'h0);
    pop(1'b1, "reclr_b5", n + 2, 32'h0);
    pop(1'b1, "reclr_b7", n + 3, 32'h0);
    no_extra("t4");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
